aes_spi_responder: RTL
======================

Name: aes_spi_responder

Overview:
- Serial-side responder (slave end) of the AES SPI link.
- Receives a 128-bit data block and a 256-bit key frame on sdi while cs is low, and hands both to an attached AES core (cipher or inverse cipher) over a start/done handshake.
- Shifts the 128-bit result back out on sdo after a fixed turnaround gap.
- One instance sits behind each chip-select of the SPI master.

Parameters:
- GAP_BITS, 4: turnaround cycles between the last key bit and the first result bit; the core result must be ready within this window.
- KEY_BITS, 256: key bits per frame; always the full 256 bits regardless of nk_val.

Ports:
- clk  in  1  system/SPI clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cs  in  1  chip select, active low.
- sdi  in  1  serial data in, sampled on posedge clk while cs=0.
- sdo  out  1  serial result out, registered, changes on posedge.
- nk_val  in  2  key length: 00=Nk4, 01=Nk6, 10=Nk8, 11 treated as Nk8.
- core_start  out  1  one-cycle start pulse to the AES core.
- core_data  out  128  received block, first received bit at [127].
- core_key  out  256  received key, first received bit at [255].
- core_nk  out  2  nk_val latched at frame start.
- core_done  in  1  core result-valid pulse.
- core_result  in  128  core output, sampled when core_done=1.
- busy  out  1  high from first sampled bit until frame end or abort.
- frame_done  out  1  one-cycle pulse after the last result bit.
- frame_err  out  1  one-cycle pulse on abort or late core.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, bit counter=0, armed=0.
  - Outputs: sdo=0, core_start=0, busy=0, frame_done=0, frame_err=0, core_data=0, core_key=0, core_nk=0.
  - Result register=0.
- States: IDLE, RX_DATA, RX_KEY, WAIT, TX.
- 9-bit counter cnt, reset to 0 on every state entry.
- IDLE:
  - armed sets when cs=1 is sampled.
  - If armed=1 and cs=0: latch nk_val into core_nk, shift sdi into core_data LSB (data shifts left), cnt=1, go to RX_DATA, busy=1, armed=0.
  - The first frame after reset needs cs to be seen high for at least one cycle.
- RX_DATA: shift sdi into core_data each cycle; after 128 total bits, go to RX_KEY.
- RX_KEY: shift sdi into core_key each cycle; after KEY_BITS bits, go to WAIT with core_start=1 on the first WAIT cycle.
  - Key alignment is the core's concern: Nk4 uses core_key[255:128], Nk6 uses [255:64], Nk8 uses all bits.
- WAIT: lasts exactly GAP_BITS cycles; sdo=0.
  - If core_done=1 in any WAIT cycle, capture core_result and set res_valid.
  - core_done in the final WAIT cycle is forwarded directly into the TX shift register.
  - On exit:
    - Load tx_shift with the result if res_valid.
    - Otherwise load zeros and pulse frame_err (late core).
- TX: sdo=tx_shift[127]; shift left each cycle; 128 cycles, MSB first.
  - The first result bit is valid in the first TX cycle.
  - After the 128th bit: sdo=0, frame_done pulse, busy=0, res_valid=0, go to IDLE.
- Frame latency from first sdi bit to first result bit = 384 + GAP_BITS cycles; total frame = 512 + GAP_BITS cycles.
- Abort: cs=1 sampled in RX_DATA, RX_KEY, WAIT or TX:
  - Return to IDLE next cycle with armed=1.
  - Pulse frame_err, busy=0, sdo=0.
  - A pending result is discarded; core_done arriving later is ignored.
  - No core_start is issued if the abort happens before RX_KEY completes.
- core_done outside WAIT is ignored.
- rst has priority over every state, including mid-TX.
- core_data, core_key and core_nk hold their values until the next frame start.

Optional Feature:
- Macro SPI_LOOPBACK_EN.
- When defined:
  - core_start is held 0 and core_done is ignored.
  - On WAIT exit, tx_shift loads core_data, echoing the received block.
  - frame_err is never raised for a late core.
- When undefined: normal core handshake as described above.

Test Plan:
- FIPS-197 Nk4: data 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f followed by 128 zero bits; stub core returns 69c4e0d86a7b0430d8cdb78070b4c55a after 2 cycles -> core_start once at cycle 384, same 128 bits on sdo starting at cycle 388, frame_done at cycle 516.
- Nk8 frame, nk_val=10: key 000102…1f -> core_nk=10, core_key matches 256 bits exactly, busy high for 516 cycles.
- Late core: stub core_done at cycle GAP_BITS+1 after start -> frame_err pulse at WAIT exit, sdo all zeros for 128 cycles, frame_done still pulses.
- Abort: cs raised after 200 bits -> no core_start, frame_err pulse, busy=0 next cycle; a following full frame completes correctly.
- Reset mid-TX after 50 result bits -> sdo=0 and all outputs at reset values next cycle; no frame_done.
- With SPI_LOOPBACK_EN: data a5a5…a5 -> sdo echoes a5a5…a5, core_start never asserted.

Source files
------------

// File: rtl/aes_spi_responder_if.sv
// Core-side handshake of the AES SPI responder: block/key/nk towards the AES core,
// start/done pulses and the 128-bit result back.
interface aes_spi_responder_if;
   logic         core_start;
   logic [127:0] core_data;
   logic [255:0] core_key;
   logic [1:0]   core_nk;
   logic         core_done;
   logic [127:0] core_result;

   modport master (
      output core_start, core_data, core_key, core_nk,
      input  core_done, core_result
   );

   modport slave (
      input  core_start, core_data, core_key, core_nk,
      output core_done, core_result
   );
endinterface

// File: rtl/aes_spi_responder.sv
// AES SPI link slave: shifts in a 128-bit block and 256-bit key, runs the AES core, shifts the result out.
// Optional SPI_LOOPBACK_EN: skip the core and echo the received block on sdo.
module aes_spi_responder #(
   parameter int unsigned GAP_BITS = 4,
   parameter int unsigned KEY_BITS = 256
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cs,
   input  logic                       sdi,
   output logic                       sdo,
   input  logic [1:0]                 nk_val,
   aes_spi_responder_if.master        core,
   output logic                       busy,
   output logic                       frame_done,
   output logic                       frame_err
);

   typedef enum logic [2:0] {S_IDLE, S_RX_DATA, S_RX_KEY, S_WAIT, S_TX} state_e;

   localparam logic [8:0] DATA_LAST = 9'd127;
   localparam logic [8:0] KEY_LAST  = 9'(KEY_BITS - 1);
   localparam logic [8:0] GAP_LAST  = 9'(GAP_BITS - 1);
   localparam logic [8:0] TX_LAST   = 9'd127;

`ifdef SPI_LOOPBACK_EN
   localparam bit LOOPBACK = 1'b1;
`else
   localparam bit LOOPBACK = 1'b0;
`endif

   state_e       state_q;
   logic [8:0]   cnt_q;
   logic         armed_q, res_valid_q;
   logic         sdo_q, start_q, busy_q, done_q, err_q;
   logic [127:0] data_q, res_q, tx_q;
   logic [255:0] key_q;
   logic [1:0]   nk_q;
   logic [127:0] tx_load_d;
   logic         late_d;

   // A core_done in the last WAIT cycle bypasses res_q so it still lands in the first TX bit.
   always_comb begin
      tx_load_d = '0;
      late_d    = 1'b0;
`ifdef SPI_LOOPBACK_EN
      tx_load_d = data_q;
`else
      if (core.core_done)
         tx_load_d = core.core_result;
      else if (res_valid_q)
         tx_load_d = res_q;
      else
         late_d = 1'b1;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         armed_q     <= 1'b0;
         res_valid_q <= 1'b0;
         sdo_q       <= 1'b0;
         start_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         data_q      <= '0;
         key_q       <= '0;
         nk_q        <= '0;
         res_q       <= '0;
         tx_q        <= '0;
      end else begin
         start_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         if (state_q != S_IDLE && cs) begin
            // Abort also drops any pending result so a late core_done cannot leak into the next frame.
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            armed_q     <= 1'b1;
            res_valid_q <= 1'b0;
            tx_q        <= '0;
            sdo_q       <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b1;
         end else begin
            case (state_q)
               S_IDLE: begin
                  sdo_q <= 1'b0;
                  if (cs) begin
                     armed_q <= 1'b1;
                  end else if (armed_q) begin
                     nk_q    <= nk_val;
                     data_q  <= {data_q[126:0], sdi};
                     cnt_q   <= 9'd1;
                     state_q <= S_RX_DATA;
                     busy_q  <= 1'b1;
                     armed_q <= 1'b0;
                  end
               end
               S_RX_DATA: begin
                  data_q <= {data_q[126:0], sdi};
                  if (cnt_q == DATA_LAST) begin
                     cnt_q   <= '0;
                     state_q <= S_RX_KEY;
                  end else begin
                     cnt_q <= cnt_q + 9'd1;
                  end
               end
               S_RX_KEY: begin
                  key_q <= {key_q[254:0], sdi};
                  if (cnt_q == KEY_LAST) begin
                     cnt_q   <= '0;
                     state_q <= S_WAIT;
                     start_q <= ~LOOPBACK;
                  end else begin
                     cnt_q <= cnt_q + 9'd1;
                  end
               end
               S_WAIT: begin
                  sdo_q <= 1'b0;
                  if (core.core_done && !LOOPBACK) begin
                     res_q       <= core.core_result;
                     res_valid_q <= 1'b1;
                  end
                  if (cnt_q == GAP_LAST) begin
                     sdo_q   <= tx_load_d[127];
                     tx_q    <= {tx_load_d[126:0], 1'b0};
                     err_q   <= late_d;
                     cnt_q   <= '0;
                     state_q <= S_TX;
                  end else begin
                     cnt_q <= cnt_q + 9'd1;
                  end
               end
               S_TX: begin
                  if (cnt_q == TX_LAST) begin
                     sdo_q       <= 1'b0;
                     done_q      <= 1'b1;
                     busy_q      <= 1'b0;
                     res_valid_q <= 1'b0;
                     cnt_q       <= '0;
                     state_q     <= S_IDLE;
                  end else begin
                     sdo_q <= tx_q[127];
                     tx_q  <= {tx_q[126:0], 1'b0};
                     cnt_q <= cnt_q + 9'd1;
                  end
               end
               default: begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
               end
            endcase
         end
      end
   end

   assign sdo             = sdo_q;
   assign busy            = busy_q;
   assign frame_done      = done_q;
   assign frame_err       = err_q;
   assign core.core_start = start_q;
   assign core.core_data  = data_q;
   assign core.core_key   = key_q;
   assign core.core_nk    = nk_q;

endmodule
